// File: rtl/load_store_unit.sv
// Memory-access-stage controller: one req/ack transaction at a time on the data bus,
// big-endian byte lanes, load data lane-aligned for the downstream load-data modifier.
module load_store_unit #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic              req_byte,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              stall,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_lb_w,
    output logic              rsp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [3:0]        r_mem_be;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_lb_w;
    logic              r_rsp_err;
    logic [7:0]        r_count;
    logic [1:0]        r_lane;
    logic              r_byte;
    logic              r_we;
    logic              w_misaligned;
    logic              w_accept_bus;
    logic              w_timeout;

    assign w_misaligned = ~req_byte & (req_addr[1:0] != 2'b00);
    assign w_accept_bus = (r_state == S_IDLE) & req_valid & ~w_misaligned;
    assign w_timeout    = (r_count == 8'(TIMEOUT - 1));

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign stall     = (req_valid & (r_state == S_WAIT)) | w_accept_bus;
    assign rsp_data  = r_rsp_data;
    assign rsp_lb_w  = r_rsp_lb_w;
    assign rsp_err   = r_rsp_err;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_be    = r_mem_be;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // An ack in the final permitted WAIT cycle takes priority over the timeout.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_next_state = w_misaligned ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_ack || w_timeout) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'b0000;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rsp_data  <= '0;
            r_rsp_lb_w  <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_count     <= 8'd0;
            r_lane      <= 2'b00;
            r_byte      <= 1'b0;
            r_we        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid && w_misaligned) begin
                        r_rsp_data <= '0;
                        r_rsp_lb_w <= req_byte & ~req_we;
                        r_rsp_err  <= 1'b1;
                    end else if (req_valid) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= req_we;
                        r_mem_be    <= req_byte ? (4'b1000 >> req_addr[1:0]) : 4'b1111;
                        r_mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                        r_mem_wdata <= req_byte ? {4{req_wdata[7:0]}} : req_wdata;
                        r_count     <= 8'd0;
                        r_lane      <= req_addr[1:0];
                        r_byte      <= req_byte;
                        r_we        <= req_we;
                    end
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        r_mem_req  <= 1'b0;
                        r_mem_we   <= 1'b0;
                        r_mem_be   <= 4'b0000;
                        r_rsp_lb_w <= r_byte & ~r_we;
                        r_rsp_err  <= 1'b0;
                        if (r_we) begin
                            r_rsp_data <= '0;
                        end else if (r_byte) begin
                            r_rsp_data <= mem_rdata << {r_lane, 3'b000};
                        end else begin
                            r_rsp_data <= mem_rdata;
                        end
                    end else if (w_timeout) begin
                        r_mem_req  <= 1'b0;
                        r_mem_we   <= 1'b0;
                        r_mem_be   <= 4'b0000;
                        r_rsp_data <= '0;
                        r_rsp_lb_w <= r_byte & ~r_we;
                        r_rsp_err  <= 1'b1;
                    end else begin
                        r_count <= r_count + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios followed by random
// transactions, each compared against a transaction-level reference model.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic        req_byte;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_lb_w;
    logic        rsp_err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int nAsserts = 0;
    int nFails   = 0;

    load_store_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_byte  (req_byte),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .stall     (stall),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_lb_w  (rsp_lb_w),
        .rsp_err   (rsp_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction: drives the request and the bus responder, and checks
    // every cycle against expectations derived from the access description alone.
    task automatic applyStimulus(input logic we, input logic byteAcc, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [31:0] rd, input int ackCycle);
        int          lane;
        bit          misaligned;
        bit          timedOut;
        int          respCycle;
        logic [3:0]  expBe;
        logic [31:0] expWd;
        logic [31:0] expRsp;
        logic        expErr;
        logic        expLbw;

        lane       = int'(addr % 4);
        misaligned = !byteAcc && lane != 0;
        timedOut   = !misaligned && ackCycle > TO;
        for (int b = 0; b < 4; b++) begin
            expBe[3 - b] = !byteAcc || (b == lane);
        end
        expWd  = byteAcc ? (wd % 256) * 32'h0101_0101 : wd;
        if (misaligned || timedOut || we) begin
            expRsp = 32'h0;
        end else if (byteAcc) begin
            expRsp = rd * (32'h1 << (8 * lane));
        end else begin
            expRsp = rd;
        end
        expErr    = misaligned || timedOut;
        expLbw    = byteAcc && !we;
        respCycle = misaligned ? 1 : (timedOut ? TO + 1 : ackCycle + 1);

        req_valid = 1'b1;
        req_we    = we;
        req_byte  = byteAcc;
        req_addr  = addr;
        req_wdata = wd;
        mem_ack   = 1'($urandom % 2);
        mem_rdata = $urandom;
        @(negedge clk);
        checkOutput("accept.req_ready", req_ready, 1'b1);
        checkOutput("accept.stall", stall, !misaligned);
        checkOutput("accept.rsp_valid", rsp_valid, 1'b0);
        nextCycle();

        for (int c = 1; c < respCycle; c++) begin
            mem_ack   = (c == ackCycle);
            mem_rdata = (c == ackCycle) ? rd : $urandom;
            @(negedge clk);
            checkOutput("wait.mem_req", mem_req, 1'b1);
            checkOutput("wait.mem_we", mem_we, we);
            checkOutput("wait.mem_be", mem_be, expBe);
            checkOutput("wait.mem_addr", mem_addr, addr - 32'(lane));
            checkOutput("wait.mem_wdata", mem_wdata, expWd);
            checkOutput("wait.stall", stall, 1'b1);
            checkOutput("wait.rsp_valid", rsp_valid, 1'b0);
            nextCycle();
        end

        req_valid = 1'b1;
        req_we    = 1'($urandom % 2);
        req_byte  = 1'($urandom % 2);
        req_addr  = $urandom;
        mem_ack   = 1'($urandom % 2);
        @(negedge clk);
        checkOutput("resp.rsp_valid", rsp_valid, 1'b1);
        checkOutput("resp.rsp_data", rsp_data, expRsp);
        checkOutput("resp.rsp_lb_w", rsp_lb_w, expLbw);
        checkOutput("resp.rsp_err", rsp_err, expErr);
        checkOutput("resp.stall", stall, 1'b0);
        checkOutput("resp.req_ready", req_ready, 1'b0);
        checkOutput("resp.mem_req", mem_req, 1'b0);
        if (!misaligned && !timedOut) begin
            checkOutput("resp.mem_be", mem_be, 4'b0000);
            checkOutput("resp.mem_we", mem_we, 1'b0);
        end
        nextCycle();

        req_valid = 1'b0;
        mem_ack   = 1'b0;
        @(negedge clk);
        checkOutput("after.rsp_valid", rsp_valid, 1'b0);
        checkOutput("after.req_ready", req_ready, 1'b1);
        checkOutput("after.mem_req", mem_req, 1'b0);
        checkOutput("after.rsp_data_hold", rsp_data, expRsp);
        checkOutput("after.rsp_err_hold", rsp_err, expErr);
        checkOutput("after.rsp_lb_w_hold", rsp_lb_w, expLbw);
        nextCycle();
    endtask

    initial begin
        logic        rWe;
        logic        rByte;
        logic [31:0] rAddr;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_byte  = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;

        #3;
        checkOutput("reset.req_ready", req_ready, 1'b1);
        checkOutput("reset.stall", stall, 1'b0);
        checkOutput("reset.rsp_valid", rsp_valid, 1'b0);
        checkOutput("reset.rsp_data", rsp_data, 32'h0);
        checkOutput("reset.rsp_err", rsp_err, 1'b0);
        checkOutput("reset.rsp_lb_w", rsp_lb_w, 1'b0);
        checkOutput("reset.mem_req", mem_req, 1'b0);
        checkOutput("reset.mem_be", mem_be, 4'b0000);
        checkOutput("reset.mem_addr", mem_addr, 32'h0);
        checkOutput("reset.mem_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nextCycle();

        $display("[TB] directed scenarios");
        applyStimulus(1'b0, 1'b0, 32'h0000_0100, 32'h0, 32'hAABB_CCDD, 3);
        applyStimulus(1'b0, 1'b1, 32'h0000_0102, 32'h0, 32'h1122_3344, 1);
        applyStimulus(1'b1, 1'b1, 32'h0000_0101, 32'h0000_00A5, 32'h0, 2);
        applyStimulus(1'b1, 1'b0, 32'h0000_0204, 32'hDEAD_BEEF, 32'h0, 1);
        applyStimulus(1'b0, 1'b0, 32'h0000_0103, 32'h0, 32'h0, 1);
        applyStimulus(1'b0, 1'b1, 32'h0000_0303, 32'h0, 32'h0102_03F4, TO);
        applyStimulus(1'b0, 1'b0, 32'h0000_0400, 32'h0, 32'h0, 99);
        applyStimulus(1'b0, 1'b0, 32'h0000_0404, 32'h0, 32'h1234_5678, 2);

        $display("[TB] reset during WAIT");
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_byte  = 1'b0;
        req_addr  = 32'h0000_0500;
        nextCycle();
        @(negedge clk);
        checkOutput("rstwait.mem_req_before", mem_req, 1'b1);
        #1;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        #1;
        checkOutput("rstwait.mem_req", mem_req, 1'b0);
        checkOutput("rstwait.req_ready", req_ready, 1'b1);
        checkOutput("rstwait.rsp_valid", rsp_valid, 1'b0);
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        nextCycle();
        mem_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            nextCycle();
            @(negedge clk);
            checkOutput("rstrel.req_ready", req_ready, 1'b1);
            checkOutput("rstrel.rsp_valid", rsp_valid, 1'b0);
            checkOutput("rstrel.mem_req", mem_req, 1'b0);
        end
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0000_0600, 32'h0, 32'hCAFE_F00D, 2);

        $display("[TB] random transactions");
        for (int n = 0; n < 40; n++) begin
            rWe   = 1'($urandom % 2);
            rByte = 1'($urandom % 2);
            rAddr = $urandom;
            if (!rByte && ($urandom % 4) != 0) begin
                rAddr = rAddr & 32'hFFFF_FFFC;
            end
            applyStimulus(rWe, rByte, rAddr, $urandom, $urandom, int'($urandom_range(1, TO + 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
